j1_io_fifo_hub: RTL
===================

Name: j1_io_fifo_hub

Overview:
Memory-mapped I/O peripheral for the j1 Forth core's io bus (io_addr/io_dout/io_rd/io_wr in, io_din out). It provides NCH independent buffered channels. Each channel has a TX FIFO (j1 writes, stream side drains) and an RX FIFO (stream side fills, j1 reads). Per-channel status/control registers and a combined interrupt line are included. It sits between dut_j1 and external streaming peripherals (UART, SPI, host mailbox) and replaces ad-hoc single-register I/O decoding.

Parameters:
DATA_W, 16, io bus and FIFO word width
ADDR_W, 16, io_addr width
NCH, 4, number of channels (1..16)
DEPTH, 8, FIFO depth per direction; power of two, >=2
BASE, 16'h4000, base io address; channel c occupies BASE+4c .. BASE+4c+3

Ports:
sys_clk_i  in  1  clock, all logic rising-edge
sys_rst_n_i  in  1  asynchronous, active-low reset
io_addr  in  ADDR_W  j1 io address
io_dout  in  DATA_W  j1 write data
io_rd  in  1  j1 read strobe, one cycle
io_wr  in  1  j1 write strobe, one cycle
io_din  out  DATA_W  read data to j1
tx_data  out  NCH*DATA_W  channel c at [c*DATA_W +: DATA_W]
tx_valid  out  NCH  TX FIFO non-empty
tx_ready  in  NCH  consumer accepts; pop when valid&ready
rx_data  in  NCH*DATA_W  producer data
rx_valid  in  NCH  producer offers word
rx_ready  out  NCH  RX FIFO not full
irq  out  1  OR over channels of enabled pending conditions

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, sticky bits 0, ctrl 0, io_din=0, tx_valid=0, rx_ready=1 (all channels), irq=0.
- Decode: hit when BASE <= io_addr < BASE+4*NCH; ch=(io_addr-BASE)>>2, off=io_addr[1:0]. Misses have no side effect, and a read miss returns 0.
- Off 0 DATA: write pushes io_dout into TX[ch]. A read pops RX[ch] and returns the popped word.
- Off 1 STATUS (read-only): bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_overflow, bit5 rx_underflow, bit6 rx_overflow, bits[15:8] rx_count. Upper bits are 0.
- Off 2 CTRL (read/write): bit0 irq_en_rx_nonempty, bit1 irq_en_tx_empty, bit2 irq_en_error. Write-only pulses: bit8 flush TX, bit9 flush RX, bit10 clear sticky errors. Pulse bits read as 0.
- Off 3: reserved. Reads return 0 and writes are ignored.
- Read latency is exactly 1 cycle: io_din is registered and valid the cycle after io_rd. It holds its value until the next io_rd.
- Write to a full TX FIFO: the word is dropped and tx_overflow is set (sticky). Fullness is evaluated before any same-cycle stream pop.
- Read from an empty RX FIFO: returns 0 and sets rx_underflow. An RX word arriving in the same cycle is not bypassed.
- rx_valid while RX is full: rx_ready is low and no word is written. rx_overflow is set only if rx_valid is held while full for more than 1 cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged and both take effect.
- Flush has priority over a same-cycle push or pop on that FIFO. The FIFO is empty the next cycle.
- io_rd and io_wr asserted together: the write takes effect and the read returns 0. This is a protocol violation, so no further guarantee is made.
- Pointers are log2(DEPTH) bits and wrap. Count is log2(DEPTH)+1 bits; full means count==DEPTH.
- irq is registered with 1 cycle latency. irq = OR over channels of (en_rx & !rx_empty) | (en_tx & tx_empty) | (en_err & any sticky).
- tx_data presents the FIFO head combinationally from storage (show-ahead).

Decomposition:
- Package j1_io_pkg holds the offset constants (OFF_DATA=0, OFF_STATUS=1, OFF_CTRL=2), the STATUS/CTRL bit indices, and a clog2 function.
- One sub-module, j1_io_fifo: a synchronous show-ahead FIFO with parameters DATA_W and DEPTH, ports push/pop/flush/full/empty/count, and the same clock and reset.
- The hub instantiates 2*NCH j1_io_fifo plus the decoder, register file and irq logic.

Test Plan:
- Write 16'h1234 then 16'hBEEF to 16'h4000 with tx_ready=0 -> tx_valid[0]=1, tx_data[0]=1234. Raise tx_ready -> next word BEEF, then tx_valid=0.
- 9 writes to 16'h4004 (ch1), tx_ready=0 -> STATUS 16'h4005 reads tx_full=1, tx_overflow=1. Drain yields exactly the first 8 words in order.
- Drive rx_valid[2] with 16'hA5A5, then io_rd at 16'h4008 -> io_din=A5A5 one cycle after io_rd. A second read returns 0 and sets rx_underflow.
- CTRL write 16'h0001 to ch3, then an RX push on ch3 -> irq rises 1 cycle later. A data read empties the FIFO and irq falls 1 cycle later.
- Fill TX ch0 with 5 words, write CTRL 16'h0100 -> tx_valid[0]=0 next cycle and STATUS shows tx_empty=1.
- Assert sys_rst_n_i low mid-burst with FIFOs partly full -> immediately tx_valid=0, irq=0, io_din=0. After release, STATUS reads 16'h000A (tx_empty, rx_empty) on every channel.

Source files
------------

// File: rtl/j1_io_fifo_hub_pkg.sv
// Shared register map constants for the j1 io FIFO hub.
// Offsets within a channel window, STATUS/CTRL bit positions, and a clog2 helper.
package j1_io_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_EMPTY  = 1;
    localparam int ST_RX_FULL   = 2;
    localparam int ST_RX_EMPTY  = 3;
    localparam int ST_TX_OVF    = 4;
    localparam int ST_RX_UNF    = 5;
    localparam int ST_RX_OVF    = 6;
    localparam int ST_RX_COUNT  = 8;

    localparam int CT_EN_RX     = 0;
    localparam int CT_EN_TX     = 1;
    localparam int CT_EN_ERR    = 2;
    localparam int CT_FLUSH_TX  = 8;
    localparam int CT_FLUSH_RX  = 9;
    localparam int CT_CLR_ERR   = 10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/j1_io_fifo.sv
// Synchronous show-ahead FIFO: head word is visible on dout_o whenever not empty.
// Push is dropped when full, pop ignored when empty, flush wins over both.
module j1_io_fifo
    import j1_io_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/j1_io_fifo_hub.sv
// Memory-mapped multi-channel TX/RX FIFO hub on the j1 io bus.
// Each channel owns a 4-word window: DATA, STATUS, CTRL, reserved.
module j1_io_fifo_hub
    import j1_io_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter int                ADDR_W = 16,
    parameter int                NCH    = 4,
    parameter int                DEPTH  = 8,
    parameter logic [ADDR_W-1:0] BASE   = 16'h4000
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_n_i,
    input  logic [ADDR_W-1:0]     io_addr,
    input  logic [DATA_W-1:0]     io_dout,
    input  logic                  io_rd,
    input  logic                  io_wr,
    output logic [DATA_W-1:0]     io_din,
    output logic [NCH*DATA_W-1:0] tx_data,
    output logic [NCH-1:0]        tx_valid,
    input  logic [NCH-1:0]        tx_ready,
    input  logic [NCH*DATA_W-1:0] rx_data,
    input  logic [NCH-1:0]        rx_valid,
    output logic [NCH-1:0]        rx_ready,
    output logic                  irq
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam logic [ADDR_W:0] BASE_X  = {1'b0, BASE};
    localparam logic [ADDR_W:0] LIMIT_X = BASE_X + (ADDR_W+1)'(4*NCH);

    logic                  hit, rd_only;
    logic [ADDR_W-1:0]     rel_unused;
    logic [1:0]            off;
    logic [NCH-1:0]        ch_sel, irq_vec;
    logic [NCH*DATA_W-1:0] rd_word_all;
    logic [DATA_W-1:0]     rd_mux;
    logic [DATA_W-1:0]     din_q;
    logic                  irq_q;

    assign hit        = ({1'b0, io_addr} >= BASE_X) && ({1'b0, io_addr} < LIMIT_X);
    assign rel_unused = io_addr - BASE;
    assign off        = io_addr[1:0];
    assign rd_only    = io_rd & ~io_wr;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic              sel, wr_data, wr_ctrl, rd_data;
        logic              flush_tx, flush_rx, clr_err;
        logic              tx_full, tx_empty, rx_full, rx_empty;
        logic [CW-1:0]     tx_count_unused, rx_count;
        logic [DATA_W-1:0] rx_head, status, rd_word;
        logic [2:0]        ctrl_q;
        logic              tx_ovf_q, rx_unf_q, rx_ovf_q, rx_block_q;

        assign sel      = hit && (rel_unused[ADDR_W-1:2] == (ADDR_W-2)'(c));
        assign wr_data  = io_wr & sel & (off == OFF_DATA);
        assign wr_ctrl  = io_wr & sel & (off == OFF_CTRL);
        assign rd_data  = rd_only & sel & (off == OFF_DATA);
        assign flush_tx = wr_ctrl & io_dout[CT_FLUSH_TX];
        assign flush_rx = wr_ctrl & io_dout[CT_FLUSH_RX];
        assign clr_err  = wr_ctrl & io_dout[CT_CLR_ERR];

        j1_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
            .clk_i   (sys_clk_i),
            .rst_n_i (sys_rst_n_i),
            .push_i  (wr_data),
            .din_i   (io_dout),
            .pop_i   (tx_ready[c]),
            .flush_i (flush_tx),
            .dout_o  (tx_data[c*DATA_W +: DATA_W]),
            .full_o  (tx_full),
            .empty_o (tx_empty),
            .count_o (tx_count_unused)
        );

        j1_io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
            .clk_i   (sys_clk_i),
            .rst_n_i (sys_rst_n_i),
            .push_i  (rx_valid[c]),
            .din_i   (rx_data[c*DATA_W +: DATA_W]),
            .pop_i   (rd_data),
            .flush_i (flush_rx),
            .dout_o  (rx_head),
            .full_o  (rx_full),
            .empty_o (rx_empty),
            .count_o (rx_count)
        );

        assign tx_valid[c] = ~tx_empty;
        assign rx_ready[c] = ~rx_full;

        // A single blocked cycle is normal backpressure; overflow means the producer kept pushing.
        always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
            if (!sys_rst_n_i) begin
                ctrl_q     <= '0;
                tx_ovf_q   <= 1'b0;
                rx_unf_q   <= 1'b0;
                rx_ovf_q   <= 1'b0;
                rx_block_q <= 1'b0;
            end else begin
                if (wr_ctrl) ctrl_q <= io_dout[2:0];
                tx_ovf_q   <= (tx_ovf_q & ~clr_err) | (wr_data & tx_full);
                rx_unf_q   <= (rx_unf_q & ~clr_err) | (rd_data & rx_empty);
                rx_ovf_q   <= (rx_ovf_q & ~clr_err) | (rx_valid[c] & rx_full & rx_block_q);
                rx_block_q <= rx_valid[c] & rx_full;
            end
        end

        always_comb begin
            status                      = '0;
            status[ST_TX_FULL]          = tx_full;
            status[ST_TX_EMPTY]         = tx_empty;
            status[ST_RX_FULL]          = rx_full;
            status[ST_RX_EMPTY]         = rx_empty;
            status[ST_TX_OVF]           = tx_ovf_q;
            status[ST_RX_UNF]           = rx_unf_q;
            status[ST_RX_OVF]           = rx_ovf_q;
            status[ST_RX_COUNT +: CW]   = rx_count;
        end

        always_comb begin
            rd_word = '0;
            case (off)
                OFF_DATA:   rd_word = rx_empty ? '0 : rx_head;
                OFF_STATUS: rd_word = status;
                OFF_CTRL:   rd_word[2:0] = ctrl_q;
                default:    rd_word = '0;
            endcase
        end

        assign ch_sel[c]                        = sel;
        assign rd_word_all[c*DATA_W +: DATA_W]  = rd_word;
        assign irq_vec[c] = (ctrl_q[CT_EN_RX] & ~rx_empty)
                          | (ctrl_q[CT_EN_TX] & tx_empty)
                          | (ctrl_q[CT_EN_ERR] & (tx_ovf_q | rx_unf_q | rx_ovf_q));
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch_sel[c]) rd_mux = rd_mux | rd_word_all[c*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            din_q <= '0;
            irq_q <= 1'b0;
        end else begin
            irq_q <= |irq_vec;
            if (io_rd) din_q <= io_wr ? '0 : rd_mux;
        end
    end

    assign io_din = din_q;
    assign irq    = irq_q;

endmodule
